// File: rtl/mips_defs_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALUOp
// codes, the control-state encoding and the datapath control word.
package mips_defs;

  // Instruction opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp codes consumed by the ALU control decoder
  localparam logic [4:0] ALUOP_RTYPE = 5'b00000;
  localparam logic [4:0] ALUOP_ADDI  = 5'b00001;
  localparam logic [4:0] ALUOP_ANDI  = 5'b00010;
  localparam logic [4:0] ALUOP_ORI   = 5'b00011;
  localparam logic [4:0] ALUOP_LUI   = 5'b00100;
  localparam logic [4:0] ALUOP_LW    = 5'b00101;
  localparam logic [4:0] ALUOP_SW    = 5'b00110;
  localparam logic [4:0] ALUOP_BEQ   = 5'b00111;
  localparam logic [4:0] ALUOP_BNE   = 5'b01000;

  // ALU B operand selects
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control states, 4-bit encoding, 13 states
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_RTYPE_WB = 4'd4,
    S_EXEC_I   = 4'd5,
    S_ITYPE_WB = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  // Complete set of datapath controls driven each cycle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_beq;
    logic       pc_write_bne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [4:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  // ALUOp for the immediate-arithmetic group
  function automatic logic [4:0] itype_alu_op(input logic [5:0] op);
    logic [4:0] code;
    code = ALUOP_ADDI;
    case (op)
      OP_ANDI: code = ALUOP_ANDI;
      OP_ORI:  code = ALUOP_ORI;
      OP_LUI:  code = ALUOP_LUI;
      default: code = ALUOP_ADDI;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_output_decode.sv
// Combinational state/opcode to control-word decoder for multicycle_control.
module control_output_decode
  import mips_defs::*;
(
  input  state_e      state_i,
  input  logic [5:0]  opcode_i,
  input  logic        mem_ready_i,
  output ctrl_t       ctrl_o
);

  // Moore decode of the state; opcode only refines ALUOp/branch strobes,
  // mem_ready only gates the FETCH-completion strobes
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_IDLE: ctrl_o = '0;
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADDI;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMMSH;
        ctrl_o.alu_op    = ALUOP_ADDI;
        case (opcode_i)
          OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI,
          OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: ctrl_o.illegal_op = 1'b0;
          default:                            ctrl_o.illegal_op = 1'b1;
        endcase
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_RTYPE;
      end
      S_RTYPE_WB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = itype_alu_op(opcode_i);
      end
      S_ITYPE_WB: begin
        ctrl_o.reg_dst   = 1'b0;
        ctrl_o.reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (opcode_i == OP_LW) ? ALUOP_LW : ALUOP_SW;
      end
      S_MEM_RD: begin
        ctrl_o.i_or_d   = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.pc_source = PCSRC_ALUOUT;
        if (opcode_i == OP_BEQ) begin
          ctrl_o.alu_op       = ALUOP_BEQ;
          ctrl_o.pc_write_beq = 1'b1;
        end else begin
          ctrl_o.alu_op       = ALUOP_BNE;
          ctrl_o.pc_write_bne = 1'b1;
        end
      end
      S_JUMP: begin
        ctrl_o.pc_source = PCSRC_JUMP;
        ctrl_o.pc_write  = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register,
// next-state sequencing and fan-out of the decoded control word.
module multicycle_control
  import mips_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_beq,
  output logic       pc_write_bne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [4:0] alu_op,
  output logic       illegal_op
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  // State register; active-low reset forces IDLE without a clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state sequencing; memory steps stretch until mem_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                         state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
          default:                          state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = S_RTYPE_WB;
      S_RTYPE_WB: state_d = S_FETCH;
      S_EXEC_I:   state_d = S_ITYPE_WB;
      S_ITYPE_WB: state_d = S_FETCH;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  control_output_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  // Fan the control word out to the individual datapath ports
  always_comb begin
    pc_write     = ctrl.pc_write;
    pc_write_beq = ctrl.pc_write_beq;
    pc_write_bne = ctrl.pc_write_bne;
    i_or_d       = ctrl.i_or_d;
    mem_read     = ctrl.mem_read;
    mem_write    = ctrl.mem_write;
    ir_write     = ctrl.ir_write;
    reg_dst      = ctrl.reg_dst;
    mem_to_reg   = ctrl.mem_to_reg;
    reg_write    = ctrl.reg_write;
    alu_src_a    = ctrl.alu_src_a;
    alu_src_b    = ctrl.alu_src_b;
    pc_source    = ctrl.pc_source;
    alu_op       = ctrl.alu_op;
    illegal_op   = ctrl.illegal_op;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each instruction is expanded into
// its step sequence, the expected control word for every cycle is queued,
// and a monitor compares the DUT outputs on the falling edge.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_beq, pc_write_bne, i_or_d;
  logic       mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [4:0] alu_op;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_beq;
    logic       pc_write_bne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [4:0] alu_op;
    logic       illegal_op;
  } cw_t;

  typedef enum {
    P_RST, P_IDLE, P_FETCH, P_DEC, P_EXR, P_RWB, P_EXI, P_IWB,
    P_MA, P_MRD, P_MWB, P_MWR, P_BR, P_J
  } phase_e;

  typedef struct {
    cw_t exp;
    int  cyc;
  } sb_t;

  sb_t   sb_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  cw_t   act;

  logic [5:0] legal_ops [10] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101,
                                 6'b001111, 6'b100011, 6'b101011, 6'b000100,
                                 6'b000101, 6'b000010};

  multicycle_control dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_beq (pc_write_beq),
    .pc_write_bne (pc_write_bne),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .pc_source    (pc_source),
    .alu_op       (alu_op),
    .illegal_op   (illegal_op)
  );

  assign act = {pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read,
                mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, pc_source, alu_op, illegal_op};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected controls for one step, straight from the step table
  function automatic cw_t exp_cw(input phase_e p, input logic [5:0] op, input logic mr);
    cw_t c;
    c = '0;
    case (p)
      P_FETCH: begin
        c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_op = 5'd1;
        c.ir_write = mr; c.pc_write = mr;
      end
      P_DEC: begin
        c.alu_src_b = 2'b11; c.alu_op = 5'd1; c.illegal_op = !is_legal(op);
      end
      P_EXR: begin c.alu_src_a = 1; c.alu_src_b = 2'b00; c.alu_op = 5'd0; end
      P_RWB: begin c.reg_dst = 1; c.reg_write = 1; end
      P_EXI: begin
        c.alu_src_a = 1; c.alu_src_b = 2'b10;
        c.alu_op = (op == 6'b001000) ? 5'd1 : (op == 6'b001100) ? 5'd2 :
                   (op == 6'b001101) ? 5'd3 : 5'd4;
      end
      P_IWB: c.reg_write = 1;
      P_MA: begin
        c.alu_src_a = 1; c.alu_src_b = 2'b10;
        c.alu_op = (op == 6'b100011) ? 5'd5 : 5'd6;
      end
      P_MRD: begin c.i_or_d = 1; c.mem_read = 1; end
      P_MWB: begin c.mem_to_reg = 1; c.reg_write = 1; end
      P_MWR: begin c.i_or_d = 1; c.mem_write = 1; end
      P_BR: begin
        c.alu_src_a = 1; c.pc_source = 2'b01;
        if (op == 6'b000100) begin c.alu_op = 5'd7; c.pc_write_beq = 1; end
        else                 begin c.alu_op = 5'd8; c.pc_write_bne = 1; end
      end
      P_J: begin c.pc_source = 2'b10; c.pc_write = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(input string name, input cw_t a, input cw_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  // Drive one cycle of stimulus and queue its expected control word
  task automatic step(input phase_e p, input logic [5:0] op, input logic mr);
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    reset = (p == P_RST) ? 1'b0 : 1'b1;
    if (p == P_DEC || p == P_EXI || p == P_MA || p == P_BR) opcode = op;
    else opcode = 6'($urandom);
    mem_ready = mr;
    e.exp = exp_cw(p, op, mr);
    e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  function automatic logic rnd_mr();
    return 1'($urandom);
  endfunction

  // Whole instruction: fw FETCH wait cycles, mw memory wait cycles
  task automatic instr(input logic [5:0] op, input int unsigned fw, input int unsigned mw);
    for (int unsigned i = 0; i < fw; i++) step(P_FETCH, op, 1'b0);
    step(P_FETCH, op, 1'b1);
    step(P_DEC, op, rnd_mr());
    case (op)
      6'b000000: begin step(P_EXR, op, rnd_mr()); step(P_RWB, op, rnd_mr()); end
      6'b001000, 6'b001100, 6'b001101, 6'b001111: begin
        step(P_EXI, op, rnd_mr()); step(P_IWB, op, rnd_mr());
      end
      6'b100011: begin
        step(P_MA, op, rnd_mr());
        for (int unsigned i = 0; i < mw; i++) step(P_MRD, op, 1'b0);
        step(P_MRD, op, 1'b1);
        step(P_MWB, op, rnd_mr());
      end
      6'b101011: begin
        step(P_MA, op, rnd_mr());
        for (int unsigned i = 0; i < mw; i++) step(P_MWR, op, 1'b0);
        step(P_MWR, op, 1'b1);
      end
      6'b000100, 6'b000101: step(P_BR, op, rnd_mr());
      6'b000010: step(P_J, op, rnd_mr());
      default: ;
    endcase
  endtask

  // Monitor: compare every cycle that has a queued expectation
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk($sformatf("cw cyc%0d", e.cyc), act, e.exp);
      end
    end
  end

  initial begin
    logic [5:0] op;
    reset = 1'b0;
    opcode = '0;
    mem_ready = 1'b0;
    step(P_RST, 6'd0, 1'b1);
    step(P_RST, 6'd0, 1'b0);
    step(P_IDLE, 6'd0, 1'b1);

    // Directed cases
    instr(6'b001000, 0, 0);   // ADDI
    instr(6'b100011, 0, 3);   // LW with 3 wait cycles in MEM_RD
    instr(6'b000101, 0, 0);   // BNE
    instr(6'b111111, 0, 0);   // illegal
    instr(6'b000000, 0, 0);   // R
    instr(6'b000010, 0, 0);   // J
    instr(6'b000100, 2, 0);   // BEQ with fetch waits
    instr(6'b101011, 1, 2);   // SW

    // Asynchronous reset in MEM_WR
    instr(6'b001100, 0, 0);
    step(P_FETCH, 6'b101011, 1'b1);
    step(P_DEC, 6'b101011, 1'b1);
    step(P_MA, 6'b101011, 1'b1);
    step(P_MWR, 6'b101011, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset mem_write", act, '0);
    step(P_RST, 6'd0, 1'b1);
    step(P_IDLE, 6'd0, 1'b1);

    // Randomised instruction stream
    for (int unsigned n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end else begin
        op = legal_ops[$urandom_range(0, 9)];
      end
      instr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
